multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle sequencing control unit for the 8-bit processor, generalised in instruction and register-field width.
//  Fetches instruction words over a valid/ready handshake and decodes the 4-bit opcode plus rd/rs fields.
//  Sequences FETCH/DECODE/IMM/EXEC/MEM/WB states and drives datapath strobes in the correct cycle.
//  Sits between the instruction memory port and the register file, ALU and data memory.
// PARAMETERS
//  IW      8   instruction and immediate word width; requires IW >= 4 + 2*RW
//  RW      2   register-field width (2**RW registers)
//  TO_CYC  15  memory-wait timeout in cycles; used only with CU_MEM_TIMEOUT_EN
// PORTS
//  clk        in   1      clock; rising edge
//  reset      in   1      asynchronous, active-high reset
//  inst       in   IW     instruction/immediate word; opcode=inst[IW-1:IW-4], rd=inst[2*RW-1:RW], rs=inst[RW-1:0]
//  inst_valid in   1      inst is valid
//  inst_ready out  1      unit accepts a word; high in FETCH and IMM only
//  mem_ack    in   1      data memory completes the current access
//  opcode     out  4      latched opcode
//  rd, rs     out  RW     latched register fields
//  imm_data   out  IW     latched immediate word
//  imm        out  1      current instruction is immediate-class; held with opcode
//  alu_src    out  1      ALU B operand = imm_data (1) or rs (0); held with opcode
//  alu_en     out  1      ALU strobe, one cycle in EXEC
//  mem_read   out  1      held high in MEM for LD until mem_ack
//  mem_write  out  1      held high in MEM for ST until mem_ack
//  reg_write  out  1      one-cycle pulse in WB
//  busy       out  1      high in every state except FETCH
//  err        out  1      sticky timeout flag; constant 0 without the macro
// BEHAVIOUR
//  Reset: state=FETCH. All outputs 0, including latches; inst_ready=1 immediately after reset.
//  Reset mid-instruction aborts the instruction. No reg_write/mem_write is issued for it.
//  FETCH: on inst_valid&inst_ready, latch inst into opcode/rd/rs and go to DECODE. No other output change.
//  DECODE (1 cycle): classify the opcode.
//   LD=0000 (mem_read, alu_src=1, writes rd). ST=0001 (mem_write, alu_src=1, no write).
//   Register ALU ops MR 0011, SUM 0100, SB 0101, ANR 0110, CM 0111, ORR 1000, XRR 1010: imm=0, alu_src=0.
//   Immediate ALU ops MI 0010, ORI 1001, XRI 1011, SMI 1100, SBI 1101, ANI 1110, CMI 1111: imm=1, alu_src=1.
//   Next state: IMM if imm=1; MEM for LD/ST; otherwise EXEC.
//   All ALU ops write rd except CM and CMI, which update flags only.
//  IMM: inst_ready=1. On handshake, latch imm_data and go to EXEC. Waits indefinitely while inst_valid=0.
//  EXEC: alu_en=1 for 1 cycle. Next state is WB if the op writes rd, else FETCH.
//  MEM: strobe held until mem_ack. mem_ack in the entry cycle completes the access in 1 cycle.
//   After mem_ack: LD goes to WB, ST goes to FETCH.
//  WB: reg_write=1 for 1 cycle, then FETCH.
//  Latency, accept-to-next-accept:
//   register ALU op with write = 4 cycles (FETCH, DECODE, EXEC, WB); CM = 3 cycles.
//   immediate op = 5 + inst_valid wait; LD = 4 + mem_ack wait; ST = 3 + mem_ack wait.
//  inst_valid outside FETCH/IMM and mem_ack outside MEM are ignored.
//  opcode, rd, rs, imm and alu_src are held from DECODE until the next FETCH accept.
//  imm_data is held until the next IMM accept.
//  Opcode field is always the top 4 bits. Unused middle bits are ignored when IW > 4 + 2*RW.
// CONFIGURATION
//  CU_MEM_TIMEOUT_EN defined:
//   a counter clears on MEM entry and counts each MEM cycle without mem_ack.
//   At TO_CYC cycles: drop the strobe, set err=1 (sticky until reset) and go to FETCH with no reg_write.
//  CU_MEM_TIMEOUT_EN undefined: no counter; MEM waits indefinitely; err tied to 0.
// TESTING
//  1. Reset, then SUM r2,r1 (inst=8'h49):
//     decode 4/2/1; alu_en in cycle 3; reg_write pulse in cycle 4; inst_ready back high in cycle 5.
//  2. ANI (8'hE4) followed by 8'h3C:
//     imm=1, alu_src=1, imm_data=8'h3C; alu_en follows; reg_write pulse. With inst_valid low 3 cycles in IMM, completion is 3 cycles later.
//  3. LD (8'h04), mem_ack asserted after 2 wait cycles:
//     mem_read high for exactly 3 cycles; reg_write pulse; ST (8'h10) with immediate mem_ack gives no reg_write.
//  4. CMI (8'hF0) + 8'h05 and CM (8'h71): alu_en pulses, reg_write stays 0 for both.
//  5. Reset asserted during MEM of ST:
//     mem_write drops asynchronously, all outputs 0, inst_ready=1 after release.
//  6. With CU_MEM_TIMEOUT_EN, TO_CYC=15: LD with mem_ack never asserted -> err=1 after 15 MEM cycles, FETCH, no reg_write.
//     With the macro undefined, the same stimulus leaves the unit in MEM and err=0.
//     Also run one non-default parameter set, IW=16 RW=4.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// ============================================================================
//  Module      : multicycle_control_unit
//  Description : Multi-cycle sequencing control unit. Fetches instruction
//                words over a valid/ready handshake, decodes the 4-bit opcode
//                and rd/rs fields, and sequences FETCH/DECODE/IMM/EXEC/MEM/WB
//                while driving the datapath strobes in the matching cycle.
//                Optional memory-wait timeout is enabled by defining the
//                macro CU_MEM_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_unit #(
   parameter int IW     = 8,
   parameter int RW     = 2,
   parameter int TO_CYC = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [IW-1:0] inst,
   input  logic          inst_valid,
   output logic          inst_ready,
   input  logic          mem_ack,
   output logic [3:0]    opcode,
   output logic [RW-1:0] rd,
   output logic [RW-1:0] rs,
   output logic [IW-1:0] imm_data,
   output logic          imm,
   output logic          alu_src,
   output logic          alu_en,
   output logic          mem_read,
   output logic          mem_write,
   output logic          reg_write,
   output logic          busy,
   output logic          err
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_IMM    = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
   } state_t;

   state_t        r_state;
   logic [3:0]    r_opcode;
   logic [RW-1:0] r_rd;
   logic [RW-1:0] r_rs;
   logic [IW-1:0] r_imm_data;
   logic          r_imm;
   logic          r_alu_src;
   logic          r_is_ld;
   logic          r_is_st;
   logic          r_writes;
   logic          r_inst_ready;
   logic          r_alu_en;
   logic          r_mem_read;
   logic          r_mem_write;
   logic          r_reg_write;
   logic          r_busy;

   logic [3:0]    w_op;
   logic          w_is_ld;
   logic          w_is_st;
   logic          w_is_imm;
   logic          w_writes;
   logic          w_unused;

`ifdef CU_MEM_TIMEOUT_EN
   localparam int CW = (TO_CYC < 2) ? 1 : $clog2(TO_CYC);
   logic [CW-1:0] r_cnt;
   logic          r_err;
`endif

   // Middle instruction bits (IW > 4 + 2*RW) carry no meaning here.
   assign w_unused = ^{inst, (TO_CYC > 0)};
   assign w_op     = inst[IW-1 -: 4];

   // Classify the incoming opcode so the class flags are ready in DECODE.
   always_comb begin
      w_is_ld  = (w_op == 4'b0000);
      w_is_st  = (w_op == 4'b0001);
      w_is_imm = 1'b0;
      case (w_op)
         4'b0010, 4'b1001, 4'b1011, 4'b1100,
         4'b1101, 4'b1110, 4'b1111: w_is_imm = 1'b1;
         default:                   w_is_imm = 1'b0;
      endcase
      // CM/CMI only update flags, ST has nothing to write back.
      w_writes = !(w_is_st || (w_op == 4'b0111) || (w_op == 4'b1111));
   end

   // Sequencer: state plus registered strobes for the state being entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_FETCH;
         r_opcode     <= '0;
         r_rd         <= '0;
         r_rs         <= '0;
         r_imm_data   <= '0;
         r_imm        <= 1'b0;
         r_alu_src    <= 1'b0;
         r_is_ld      <= 1'b0;
         r_is_st      <= 1'b0;
         r_writes     <= 1'b0;
         r_inst_ready <= 1'b1;
         r_alu_en     <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_reg_write  <= 1'b0;
         r_busy       <= 1'b0;
`ifdef CU_MEM_TIMEOUT_EN
         r_cnt        <= '0;
         r_err        <= 1'b0;
`endif
      end else begin
         r_alu_en    <= 1'b0;
         r_reg_write <= 1'b0;
         case (r_state)
            S_FETCH: begin
               if (inst_valid && r_inst_ready) begin
                  r_opcode     <= w_op;
                  r_rd         <= inst[2*RW-1 -: RW];
                  r_rs         <= inst[RW-1:0];
                  r_imm        <= w_is_imm;
                  r_alu_src    <= w_is_imm | w_is_ld | w_is_st;
                  r_is_ld      <= w_is_ld;
                  r_is_st      <= w_is_st;
                  r_writes     <= w_writes;
                  r_inst_ready <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (r_imm) begin
                  r_inst_ready <= 1'b1;
                  r_state      <= S_IMM;
               end else if (r_is_ld || r_is_st) begin
                  r_mem_read  <= r_is_ld;
                  r_mem_write <= r_is_st;
`ifdef CU_MEM_TIMEOUT_EN
                  r_cnt       <= '0;
`endif
                  r_state     <= S_MEM;
               end else begin
                  r_alu_en <= 1'b1;
                  r_state  <= S_EXEC;
               end
            end
            S_IMM: begin
               if (inst_valid && r_inst_ready) begin
                  r_imm_data   <= inst;
                  r_inst_ready <= 1'b0;
                  r_alu_en     <= 1'b1;
                  r_state      <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (r_writes) begin
                  r_reg_write <= 1'b1;
                  r_state     <= S_WB;
               end else begin
                  r_inst_ready <= 1'b1;
                  r_busy       <= 1'b0;
                  r_state      <= S_FETCH;
               end
            end
            S_MEM: begin
               if (mem_ack) begin
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 1'b0;
                  if (r_is_ld) begin
                     r_reg_write <= 1'b1;
                     r_state     <= S_WB;
                  end else begin
                     r_inst_ready <= 1'b1;
                     r_busy       <= 1'b0;
                     r_state      <= S_FETCH;
                  end
               end
`ifdef CU_MEM_TIMEOUT_EN
               // Last allowed wait cycle without an ack: abandon the access.
               else if (r_cnt == CW'(TO_CYC - 1)) begin
                  r_mem_read   <= 1'b0;
                  r_mem_write  <= 1'b0;
                  r_err        <= 1'b1;
                  r_inst_ready <= 1'b1;
                  r_busy       <= 1'b0;
                  r_state      <= S_FETCH;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
`endif
            end
            S_WB: begin
               r_inst_ready <= 1'b1;
               r_busy       <= 1'b0;
               r_state      <= S_FETCH;
            end
            default: begin
               r_inst_ready <= 1'b1;
               r_busy       <= 1'b0;
               r_mem_read   <= 1'b0;
               r_mem_write  <= 1'b0;
               r_state      <= S_FETCH;
            end
         endcase
      end
   end

   assign inst_ready = r_inst_ready;
   assign opcode     = r_opcode;
   assign rd         = r_rd;
   assign rs         = r_rs;
   assign imm_data   = r_imm_data;
   assign imm        = r_imm;
   assign alu_src    = r_alu_src;
   assign alu_en     = r_alu_en;
   assign mem_read   = r_mem_read;
   assign mem_write  = r_mem_write;
   assign reg_write  = r_reg_write;
   assign busy       = r_busy;
`ifdef CU_MEM_TIMEOUT_EN
   assign err        = r_err;
`else
   assign err        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
//  Module      : tb_multicycle_control_unit
//  Description : Self-checking bench for multicycle_control_unit. A cycle
//                schedule per instruction is derived from the opcode class
//                and compared against the unit's strobes and latched fields.
//                A second instance runs with IW=16, RW=4.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multicycle_control_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] inst = '0;
   logic       inst_valid = 1'b0;
   logic       mem_ack = 1'b0;
   logic       inst_ready, imm, alu_src, alu_en, mem_read, mem_write, reg_write, busy, err;
   logic [3:0] opcode;
   logic [1:0] rd, rs;
   logic [7:0] imm_data;

   logic [15:0] wd_inst = '0;
   logic        wd_valid = 1'b0;
   logic        wd_ack = 1'b0;
   logic        wd_ready, wd_imm, wd_alu_src, wd_alu_en, wd_mem_read, wd_mem_write;
   logic        wd_reg_write, wd_busy, wd_err;
   logic [3:0]  wd_opcode, wd_rd, wd_rs;
   logic [15:0] wd_imm_data;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model of the architecturally visible latched state
   logic [3:0] m_op;
   logic [1:0] m_rd, m_rs;
   logic       m_imm, m_src, m_err;
   logic [7:0] m_immdata;

   multicycle_control_unit #(.IW(8), .RW(2), .TO_CYC(15)) u_dut (
      .clk(clk), .reset(reset), .inst(inst), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .mem_ack(mem_ack), .opcode(opcode), .rd(rd), .rs(rs),
      .imm_data(imm_data), .imm(imm), .alu_src(alu_src), .alu_en(alu_en),
      .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
      .busy(busy), .err(err)
   );

   multicycle_control_unit #(.IW(16), .RW(4), .TO_CYC(15)) u_dut_wide (
      .clk(clk), .reset(reset), .inst(wd_inst), .inst_valid(wd_valid),
      .inst_ready(wd_ready), .mem_ack(wd_ack), .opcode(wd_opcode), .rd(wd_rd), .rs(wd_rs),
      .imm_data(wd_imm_data), .imm(wd_imm), .alu_src(wd_alu_src), .alu_en(wd_alu_en),
      .mem_read(wd_mem_read), .mem_write(wd_mem_write), .reg_write(wd_reg_write),
      .busy(wd_busy), .err(wd_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete (time %0t, required finish)", $time);
      $fatal(1, "watchdog");
   end

   // Opcode class from the instruction table: {immediate, load, store, writes rd}
   function automatic logic [3:0] classify(input logic [3:0] op);
      logic ci, ld, st, wr;
      ci = op inside {4'h2, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
      ld = (op == 4'h0);
      st = (op == 4'h1);
      wr = !(st || op == 4'h7 || op == 4'hF);
      return {ci, ld, st, wr};
   endfunction

   function automatic logic [6:0] ev(input logic rdy, input logic bsy, input logic alu,
                                      input logic mr, input logic mw, input logic rw);
      return {rdy, bsy, alu, mr, mw, rw, m_err};
   endfunction

   function automatic logic rbit();
      return 1'($urandom);
   endfunction

   task automatic latch_model(input logic [7:0] w);
      logic [3:0] c;
      c     = classify(w[7:4]);
      m_op  = w[7:4];
      m_rd  = w[3:2];
      m_rs  = w[1:0];
      m_imm = c[3];
      m_src = c[3] | c[2] | c[1];
   endtask

   // Check the current cycle against the schedule, then drive this cycle's inputs.
   task automatic cycle(input logic [6:0] exp, input logic v, input logic [7:0] d,
                        input logic a, input string ph);
      logic [6:0]  act;
      logic [17:0] fa, fe;
      act = {inst_ready, busy, alu_en, mem_read, mem_write, reg_write, err};
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s strobes{rdy,busy,alu,mrd,mwr,rwr,err}: got %b want %b", ph, act, exp);
      end
      fa = {opcode, rd, rs, imm, alu_src, imm_data};
      fe = {m_op, m_rd, m_rs, m_imm, m_src, m_immdata};
      n_checks++;
      if (fa !== fe) begin
         n_err++;
         $display("FAIL %s fields{op,rd,rs,imm,src,immdata}: got %h want %h", ph, fa, fe);
      end
      inst_valid = v;
      inst       = d;
      mem_ack    = a;
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input logic [7:0] w, input logic [7:0] iw, input int idle,
                            input int iwait, input int awt, input string nm);
      logic [3:0] c;
      c = classify(w[7:4]);
      for (int k = 0; k < idle; k++)
         cycle(ev(1, 0, 0, 0, 0, 0), 1'b0, 8'($urandom), rbit(), {nm, "-idle"});
      cycle(ev(1, 0, 0, 0, 0, 0), 1'b1, w, rbit(), {nm, "-fetch"});
      latch_model(w);
      cycle(ev(0, 1, 0, 0, 0, 0), rbit(), 8'($urandom), rbit(), {nm, "-decode"});
      if (c[3]) begin
         for (int k = 0; k <= iwait; k++)
            cycle(ev(1, 1, 0, 0, 0, 0), (k == iwait), (k == iwait) ? iw : 8'($urandom),
                  rbit(), {nm, "-imm"});
         m_immdata = iw;
      end
      if (c[2] | c[1]) begin
         for (int k = 0; k <= awt; k++)
            cycle(ev(0, 1, 0, c[2], c[1], 0), rbit(), 8'($urandom), (k == awt), {nm, "-mem"});
      end else begin
         cycle(ev(0, 1, 1, 0, 0, 0), rbit(), 8'($urandom), rbit(), {nm, "-exec"});
      end
      if (c[0])
         cycle(ev(0, 1, 0, 0, 0, 1), rbit(), 8'($urandom), rbit(), {nm, "-wb"});
   endtask

   task automatic apply_reset(input string nm);
      logic [5:0]  act;
      logic [17:0] fa;
      reset      = 1'b1;
      inst_valid = 1'b0;
      mem_ack    = 1'b0;
      #1;
      act = {busy, alu_en, mem_read, mem_write, reg_write, err};
      n_checks++;
      if (act !== 6'b0) begin
         n_err++;
         $display("FAIL %s outputs during reset{busy,alu,mrd,mwr,rwr,err}: got %b want 000000", nm, act);
      end
      fa = {opcode, rd, rs, imm, alu_src, imm_data};
      n_checks++;
      if (fa !== 18'h0) begin
         n_err++;
         $display("FAIL %s latches during reset: got %h want 0", nm, fa);
      end
      m_op = '0; m_rd = '0; m_rs = '0; m_imm = 1'b0; m_src = 1'b0; m_immdata = '0; m_err = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      @(posedge clk);
      #1;
      apply_reset("reset");
      cycle(ev(1, 0, 0, 0, 0, 0), 1'b0, 8'h00, 1'b0, "reset-fetch");
   endtask

   task automatic test_sum;
      run_instr(8'h49, 8'h00, 0, 0, 0, "sum");
      run_instr(8'h49, 8'h00, 1, 0, 0, "sum2");
   endtask

   task automatic test_ani;
      run_instr(8'hE4, 8'h3C, 0, 0, 0, "ani");
      run_instr(8'hE4, 8'hC3, 0, 3, 0, "ani-wait");
   endtask

   task automatic test_ld_st;
      run_instr(8'h04, 8'h00, 0, 0, 2, "ld");
      run_instr(8'h10, 8'h00, 0, 0, 0, "st");
   endtask

   task automatic test_cmp;
      run_instr(8'hF0, 8'h05, 0, 0, 0, "cmi");
      run_instr(8'h71, 8'h00, 0, 0, 0, "cm");
   endtask

   task automatic test_random;
      for (int n = 0; n < 40; n++)
         run_instr(8'($urandom), 8'($urandom), $urandom_range(0, 2),
                   $urandom_range(0, 3), $urandom_range(0, 4), "rand");
   endtask

   task automatic test_reset_mid_mem;
      cycle(ev(1, 0, 0, 0, 0, 0), 1'b1, 8'h1B, 1'b0, "rstmem-fetch");
      latch_model(8'h1B);
      cycle(ev(0, 1, 0, 0, 0, 0), 1'b0, 8'h00, 1'b0, "rstmem-decode");
      cycle(ev(0, 1, 0, 0, 1, 0), 1'b0, 8'h00, 1'b0, "rstmem-mem");
      #2;
      apply_reset("rstmem");
      for (int k = 0; k < 3; k++)
         cycle(ev(1, 0, 0, 0, 0, 0), 1'b0, 8'h00, rbit(), "rstmem-after");
   endtask

   task automatic test_timeout;
      logic [7:0] w;
      w = {4'b0000, 4'($urandom)};
      cycle(ev(1, 0, 0, 0, 0, 0), 1'b1, w, 1'b0, "to-fetch");
      latch_model(w);
      cycle(ev(0, 1, 0, 0, 0, 0), rbit(), 8'($urandom), 1'b0, "to-decode");
`ifdef CU_MEM_TIMEOUT_EN
      for (int k = 0; k < 15; k++)
         cycle(ev(0, 1, 0, 1, 0, 0), rbit(), 8'($urandom), 1'b0, "to-mem");
      m_err = 1'b1;
      cycle(ev(1, 0, 0, 0, 0, 0), 1'b0, 8'h00, 1'b0, "to-expired");
      run_instr(8'h49, 8'h00, 1, 0, 0, "to-sticky");
      apply_reset("to-clear");
      cycle(ev(1, 0, 0, 0, 0, 0), 1'b0, 8'h00, 1'b0, "to-cleared");
`else
      for (int k = 0; k < 20; k++)
         cycle(ev(0, 1, 0, 1, 0, 0), rbit(), 8'($urandom), 1'b0, "to-hold");
      apply_reset("to-recover");
      cycle(ev(1, 0, 0, 0, 0, 0), 1'b0, 8'h00, 1'b0, "to-recovered");
`endif
   endtask

   task automatic test_wide;
      logic [15:0] word, iw;
      logic [3:0]  c;
      int iwait, awt, ki, km, lat, exp_lat, n_alu, n_rw, n_rd, n_wr;
      for (int n = 0; n < 16; n++) begin
         word  = 16'($urandom);
         iw    = 16'($urandom);
         c     = classify(word[15:12]);
         iwait = $urandom_range(0, 2);
         awt   = $urandom_range(0, 3);
         n_checks++;
         if (wd_ready !== 1'b1 || wd_busy !== 1'b0) begin
            n_err++;
            $display("FAIL wide-fetch ready/busy: got %b%b want 10", wd_ready, wd_busy);
         end
         wd_valid = 1'b1;
         wd_inst  = word;
         @(posedge clk);
         #1;
         wd_valid = 1'b0;
         wd_inst  = 16'($urandom);
         n_checks++;
         if ({wd_opcode, wd_rd, wd_rs, wd_imm, wd_alu_src} !==
             {word[15:12], word[7:4], word[3:0], c[3], c[3] | c[2] | c[1]}) begin
            n_err++;
            $display("FAIL wide-decode inst=%h: got %h/%h/%h imm=%b src=%b", word,
                     wd_opcode, wd_rd, wd_rs, wd_imm, wd_alu_src);
         end
         lat = 1; ki = 0; km = 0; n_alu = 0; n_rw = 0; n_rd = 0; n_wr = 0;
         while (!(wd_ready && !wd_busy) && lat < 40) begin
            if (wd_ready && wd_busy) begin
               wd_valid = (ki == iwait);
               wd_inst  = (ki == iwait) ? iw : 16'($urandom);
               ki++;
            end
            if (wd_mem_read || wd_mem_write) begin
               wd_ack = (km == awt);
               km++;
            end
            n_alu += int'(wd_alu_en);
            n_rw  += int'(wd_reg_write);
            n_rd  += int'(wd_mem_read);
            n_wr  += int'(wd_mem_write);
            @(posedge clk);
            #1;
            wd_valid = 1'b0;
            wd_ack   = 1'b0;
            lat++;
         end
         exp_lat = 2 + (c[3] ? iwait + 1 : 0) + ((c[2] | c[1]) ? awt + 1 : 1) + int'(c[0]);
         n_checks++;
         if (lat != exp_lat) begin
            n_err++;
            $display("FAIL wide-latency inst=%h: got %0d want %0d", word, lat, exp_lat);
         end
         n_checks++;
         if (n_alu != int'(!(c[2] | c[1])) || n_rw != int'(c[0]) ||
             n_rd != (c[2] ? awt + 1 : 0) || n_wr != (c[1] ? awt + 1 : 0)) begin
            n_err++;
            $display("FAIL wide-strobes inst=%h: got alu=%0d rw=%0d rd=%0d wr=%0d want %0d/%0d/%0d/%0d",
                     word, n_alu, n_rw, n_rd, n_wr, int'(!(c[2] | c[1])), int'(c[0]),
                     c[2] ? awt + 1 : 0, c[1] ? awt + 1 : 0);
         end
         if (c[3]) begin
            n_checks++;
            if (wd_imm_data !== iw) begin
               n_err++;
               $display("FAIL wide-imm_data: got %h want %h", wd_imm_data, iw);
            end
         end
      end
   endtask

   initial begin
      m_op = '0; m_rd = '0; m_rs = '0; m_imm = 1'b0; m_src = 1'b0; m_immdata = '0; m_err = 1'b0;
      test_reset();
      test_sum();
      test_ani();
      test_ld_st();
      test_cmp();
      test_random();
      test_reset_mid_mem();
      test_timeout();
      test_wide();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

`default_nettype wire
